// File: rtl/mem_interface.sv
// Memory bus interface: one req/ack transaction per core access, lane-aligned extended read data.
// Latency: request cycle + >=1 REQ cycle + DONE (3 cycles at zero wait states); bus outputs registered.
// Backpressure: Stall holds the core while a request is pending or outstanding; timeouts and illegal accesses fault stickily.
module mem_interface #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  funct3,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MemFault,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusBe,
    input  logic        BusAck,
    input  logic [31:0] BusRData
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_t;

    state_t      r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_bus_addr, r_bus_wdata, r_read_data;
    logic [3:0]  r_bus_be;
    logic        r_bus_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;

    logic        w_req, w_legal, w_accept;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_req = MemRead | MemWrite;

    // Access decode; MemWrite wins when both request lines are high.
    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'hF;
        w_wdata = WriteData;
        case (funct3)
            3'b000: begin
                w_legal = 1'b1;
                w_wdata = {4{WriteData[7:0]}};
                if (MemWrite) w_be = 4'b0001 << Adr[1:0];
            end
            3'b001: begin
                w_legal = ~Adr[0];
                w_wdata = {2{WriteData[15:0]}};
                if (MemWrite) w_be = 4'b0011 << Adr[1:0];
            end
            3'b010:         w_legal = (Adr[1:0] == 2'b00);
            3'b100:         w_legal = ~MemWrite;
            3'b101:         w_legal = ~MemWrite & ~Adr[0];
            default:        w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_legal) begin
                        w_next   = S_REQ;
                        w_accept = 1'b1;
                    end else begin
                        w_next = S_FAULT;
                    end
                end
            end
            S_REQ: begin
                if (BusAck)              w_next = S_DONE;
                else if (r_cnt == LAST)  w_next = S_FAULT;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        case (r_lane)
            2'd0:    w_byte = BusRData[7:0];
            2'd1:    w_byte = BusRData[15:8];
            2'd2:    w_byte = BusRData[23:16];
            default: w_byte = BusRData[31:24];
        endcase
        w_half = r_lane[1] ? BusRData[31:16] : BusRData[15:0];
        case (r_funct3[1:0])
            2'b00:   w_ext = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
            2'b01:   w_ext = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
            default: w_ext = BusRData;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
            r_bus_we    <= 1'b0;
            r_funct3    <= '0;
            r_lane      <= '0;
            r_read_data <= '0;
        end else begin
            if (w_accept) begin
                r_cnt       <= '0;
                r_bus_addr  <= {Adr[31:2], 2'b00};
                r_bus_wdata <= w_wdata;
                r_bus_be    <= w_be;
                r_bus_we    <= MemWrite;
                r_funct3    <= funct3;
                r_lane      <= Adr[1:0];
            end else if (r_state == S_REQ && !BusAck && r_cnt != LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_REQ && BusAck && !r_bus_we)
                r_read_data <= w_ext;
        end
    end

    assign BusReq   = (r_state == S_REQ);
    assign MemFault = (r_state == S_FAULT);
    assign BusWe    = r_bus_we;
    assign BusAddr  = r_bus_addr;
    assign BusWData = r_bus_wdata;
    assign BusBe    = r_bus_be;
    assign ReadData = r_read_data;
    assign Stall    = ~reset & (((r_state == S_IDLE) & w_req) | (r_state == S_REQ) |
                                (r_state == S_FAULT));

endmodule
